// File: rtl/display_pkg.sv
// Shared types and defaults for the multiplexed seven-segment display scanner.
package display_pkg;

  typedef enum logic {S_DEAD, S_DRIVE} scan_state_t;

  localparam int unsigned DISP_DIGITS      = 4;
  localparam int unsigned DISP_REFRESH_DIV = 50000;
  localparam int unsigned DISP_DEAD_CYCLES = 500;
  localparam int unsigned NIBBLE_W         = 4;
  localparam int unsigned MAX_DIGITS       = 8;

  // Digit k is a leading zero when it and every higher digit hold zero; digit 0 always lights.
  function automatic logic lz_blank(input logic [31:0] val, input int unsigned k,
                                    input int unsigned digits);
    logic nz;
    nz = 1'b0;
    for (int unsigned i = 0; i < MAX_DIGITS; i++) begin
      if (i >= k && i < digits && val[NIBBLE_W*i +: NIBBLE_W] != 4'h0) nz = 1'b1;
    end
    return (k != 0) && !nz;
  endfunction

endpackage

// File: rtl/display_scan_controller_if.sv
// Load/value request side and decoder/anode drive side of the display scanner.
interface display_scan_controller_if
  import display_pkg::*;
#(
  parameter int unsigned DIGITS = DISP_DIGITS
);
  logic                  load;
  logic [4*DIGITS-1:0]   value;
  logic [3:0]            number;
  logic [DIGITS-1:0]     anode;
  logic                  blank;
  logic                  pending;
  logic                  frame_done;

  modport master (output load, value,
                  input  number, anode, blank, pending, frame_done);
  modport slave  (input  load, value,
                  output number, anode, blank, pending, frame_done);
endinterface

// File: rtl/display_refresh_timer.sv
// Free-running slot counter 0..REFRESH_DIV-1 flagging the dead-end and slot-end cycles.
module display_refresh_timer
  import display_pkg::*;
#(
  parameter int unsigned REFRESH_DIV = DISP_REFRESH_DIV,
  parameter int unsigned DEAD_CYCLES = DISP_DEAD_CYCLES
) (
  input  logic clk,
  input  logic rst_n,
  output logic dead_end_c,
  output logic slot_end_c
);
  localparam int unsigned CNT_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;

  logic [CNT_W-1:0] cnt;

  assign dead_end_c = (cnt == CNT_W'(DEAD_CYCLES - 1));
  assign slot_end_c = (cnt == CNT_W'(REFRESH_DIV - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)          cnt <= '0;
    else if (slot_end_c) cnt <= '0;
    else                 cnt <= cnt + CNT_W'(1);
  end

endmodule

// File: rtl/display_scan_controller.sv
// Double-buffered BCD digit scanner with dead time and frame-aligned updates.
// Optional leading-zero blanking when DISPLAY_LZ_BLANK_EN is defined.
module display_scan_controller
  import display_pkg::*;
#(
  parameter int unsigned DIGITS      = DISP_DIGITS,
  parameter int unsigned REFRESH_DIV = DISP_REFRESH_DIV,
  parameter int unsigned DEAD_CYCLES = DISP_DEAD_CYCLES
) (
  input  logic                      clk,
  input  logic                      rst_n,
  display_scan_controller_if.slave  bus
);
  localparam int unsigned IDX_W = $clog2(DIGITS);

  typedef logic [DIGITS-1:0][NIBBLE_W-1:0] digits_t;

  scan_state_t        state;
  logic [IDX_W-1:0]   idx;
  digits_t            active;
  digits_t            shadow;
  logic               pending;
  logic [3:0]         number;
  logic [DIGITS-1:0]  anode;
  logic               blank;
  logic               frame_done;

  logic               dead_end_c;
  logic               slot_end_c;
  logic               wrap_c;
  logic [IDX_W-1:0]   idx_nxt_c;
  digits_t            active_nxt_c;
  logic               blank_nxt_c;

  display_refresh_timer #(
    .REFRESH_DIV (REFRESH_DIV),
    .DEAD_CYCLES (DEAD_CYCLES)
  ) u_timer (
    .clk        (clk),
    .rst_n      (rst_n),
    .dead_end_c (dead_end_c),
    .slot_end_c (slot_end_c)
  );

  // Next digit index and frame-boundary value swap (a load on the wrap cycle bypasses the shadow).
  always_comb begin
    wrap_c       = slot_end_c && (idx == IDX_W'(DIGITS - 1));
    idx_nxt_c    = idx;
    active_nxt_c = active;
    if (slot_end_c) idx_nxt_c = wrap_c ? '0 : idx + IDX_W'(1);
    if (wrap_c) begin
      if (bus.load)    active_nxt_c = digits_t'(bus.value);
      else if (pending) active_nxt_c = shadow;
    end
`ifdef DISPLAY_LZ_BLANK_EN
    blank_nxt_c = lz_blank(32'(active_nxt_c), 32'(idx_nxt_c), DIGITS);
`else
    blank_nxt_c = 1'b0;
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= S_DEAD;
      idx        <= '0;
      active     <= '0;
      shadow     <= '0;
      pending    <= 1'b0;
      number     <= '0;
      anode      <= '1;
      blank      <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      frame_done <= wrap_c;
      if (bus.load) shadow <= digits_t'(bus.value);
      if (wrap_c)        pending <= 1'b0;
      else if (bus.load) pending <= 1'b1;
      active <= active_nxt_c;
      idx    <= idx_nxt_c;
      blank  <= blank_nxt_c;
      // Nibble is presented during dead time so the decoder settles before the anode turns on.
      number <= active_nxt_c[idx_nxt_c];
      case (state)
        S_DEAD: begin
          if (dead_end_c) begin
            state <= S_DRIVE;
            anode <= blank ? '1 : ~(DIGITS'(1) << idx);
          end
        end
        S_DRIVE: begin
          if (slot_end_c) begin
            state <= S_DEAD;
            anode <= '1;
          end
        end
        default: begin
          state <= S_DEAD;
          anode <= '1;
        end
      endcase
    end
  end

  assign bus.number     = number;
  assign bus.anode      = anode;
  assign bus.blank      = blank;
  assign bus.pending    = pending;
  assign bus.frame_done = frame_done;

endmodule
